proc_control: RTL and testbench
===============================

PROC_CONTROL -- requirements
Module: proc_control

Interface
REQ-001 Parameters SHALL be none; all encodings come from package proc_pkg.
REQ-002 clk  input  1  rising-edge clock.
REQ-003 resetn  input  1  synchronous active-low reset, sampled on the rising edge of clk.
REQ-004 run  input  1  start request; sampled only in IDLE.
REQ-005 instr  input  16  instruction word, captured into ir when run is accepted.
REQ-006 ir  output  16  registered instruction, fed to the bus mux for immediate fields.
REQ-007 bus_sel  output  4  bus mux select:
  - 0..7 = r0..r7
  - 8 = G
  - 9 = D (zero-extended ir[8:0])
  - 10 = DT (ir[7:0] shifted left by 8)
REQ-008 r_in  output  8  one-hot register write enables, r_in[k] writes rk.
REQ-009 a_in  output  1  load the ALU A register from the bus.
REQ-010 g_in  output  1  load the G register with the ALU result.
REQ-011 add_sub  output  1  ALU operation: 0 = add, 1 = subtract.
REQ-012 done  output  1  one-cycle pulse in the final cycle of an instruction.
REQ-013 busy  output  1  high in every state except IDLE.

Function
REQ-014 The ir fields SHALL be decoded as:
  - op = ir[15:13]
  - imm = ir[12]
  - rX = ir[11:9]
  - rY = ir[2:0]
  - D = ir[8:0]
REQ-015 The opcodes SHALL be: 000 mv, 001 mvt, 010 add, 011 sub; 100..111 undefined.
REQ-016 The FSM SHALL have states IDLE, T1, T2, T3; the state is registered and outputs are decoded combinationally from state and ir.
REQ-017 IDLE: all enables and done SHALL be 0 and bus_sel SHALL be 0; when run=1, ir <= instr and next state is T1, otherwise stay in IDLE.
REQ-018 T1 for mv SHALL drive bus_sel = imm ? 9 : rY, assert r_in[rX] and done, then go to IDLE.
REQ-019 T1 for mvt SHALL drive bus_sel = 10, assert r_in[rX] and done, then go to IDLE.
REQ-020 T1 for add/sub SHALL drive bus_sel = rX, assert a_in, then go to T2.
REQ-021 T2 SHALL drive bus_sel = imm ? 9 : rY, assert g_in, set add_sub = (op==011), then go to T3.
REQ-022 T3 SHALL drive bus_sel = 8, assert r_in[rX] and done, then go to IDLE.
REQ-023 T1 for an undefined op SHALL assert done only: no enables, bus_sel = 0, then go to IDLE.
REQ-024 Latency from run acceptance to done SHALL be:
  - mv/mvt/undefined: 1 cycle (done in T1)
  - add/sub: 3 cycles (done in T3)
REQ-025 At most one r_in bit SHALL be high in any cycle; a_in, g_in and any r_in bit SHALL never be high together.
REQ-026 run while busy SHALL be ignored, and ir SHALL hold until the next accepted run.
REQ-027 The next instruction SHALL be accepted no earlier than the cycle after done; one IDLE cycle always separates instructions.
REQ-028 add_sub SHALL be 0 in every state other than T2.
REQ-029 rX = rY (e.g. add r3,r3) SHALL be legal and follow the same sequence.

Reset
REQ-030 When resetn=0 at a rising clk edge, the next state SHALL be IDLE and ir <= 16'h0000, in any state, including mid-instruction.
REQ-031 After reset, outputs SHALL be: bus_sel=0, r_in=0, a_in=0, g_in=0, add_sub=0, done=0, busy=0.
REQ-032 run asserted during reset SHALL be ignored; the first acceptance occurs on the first edge with resetn=1.

Structure
REQ-033 proc_pkg SHALL hold the select codes SEL_R0..SEL_R7, SEL_G=8, SEL_D=9, SEL_DT=10, the opcode constants, and the state encoding.
REQ-034 The select codes SHALL be shared with the bus mux so both agree on encoding.
REQ-035 One sub-module dec3to8 (3-bit index to one-hot 8 with enable) SHALL generate r_in.

Verification
REQ-036 Reset, then run=1 with instr=16'h2605 (mvt r3, D=0x05) -> T1: bus_sel=10, r_in=8'h08, done=1; busy=0 next cycle.
REQ-037 instr=16'h1E1A (mv imm r7, D=0x1A) -> T1: bus_sel=9, r_in=8'h80, done=1.
REQ-038 instr=16'h4205 (add r1,r5) -> T1: bus_sel=1, a_in=1; T2: bus_sel=5, g_in=1, add_sub=0; T3: bus_sel=8, r_in=8'h02, done=1.
REQ-039 instr=16'h7403 (sub imm r2, D=3) -> T2: bus_sel=9, add_sub=1; T3: r_in=8'h04, done=1.
REQ-040 run held high through an add sequence -> no restart before IDLE; ir holds 16'h4205 until the next acceptance.
REQ-041 resetn=0 in T2 of an add -> next cycle IDLE, all outputs 0, ir=0; a following instr=16'hE000 (undefined) -> done only in T1.

Source files
------------

// File: rtl/proc_pkg.sv
// Shared encodings for the processor control slice: bus-mux selects, opcodes, FSM states.
// The datapath bus mux imports the same select codes so both sides agree.
package proc_pkg;

  localparam logic [3:0] SEL_R0 = 4'd0;
  localparam logic [3:0] SEL_R1 = 4'd1;
  localparam logic [3:0] SEL_R2 = 4'd2;
  localparam logic [3:0] SEL_R3 = 4'd3;
  localparam logic [3:0] SEL_R4 = 4'd4;
  localparam logic [3:0] SEL_R5 = 4'd5;
  localparam logic [3:0] SEL_R6 = 4'd6;
  localparam logic [3:0] SEL_R7 = 4'd7;
  localparam logic [3:0] SEL_G  = 4'd8;
  localparam logic [3:0] SEL_D  = 4'd9;
  localparam logic [3:0] SEL_DT = 4'd10;

  localparam logic [2:0] OP_MV  = 3'b000;
  localparam logic [2:0] OP_MVT = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b011;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_T1   = 2'd1;
  localparam logic [1:0] ST_T2   = 2'd2;
  localparam logic [1:0] ST_T3   = 2'd3;

  // Register index rN maps directly onto select code N.
  function automatic logic [3:0] sel_reg(input logic [2:0] r);
    return {1'b0, r};
  endfunction

endpackage

// File: rtl/proc_control_if.sv
// Control <-> datapath signal bundle; master is the controller, slave the datapath/bench side.
interface proc_control_if;
  logic        run;
  logic [15:0] instr;
  logic [15:0] ir;
  logic [3:0]  bus_sel;
  logic [7:0]  r_in;
  logic        a_in;
  logic        g_in;
  logic        add_sub;
  logic        done;
  logic        busy;

  modport master (
    input  run, instr,
    output ir, bus_sel, r_in, a_in, g_in, add_sub, done, busy
  );

  modport slave (
    output run, instr,
    input  ir, bus_sel, r_in, a_in, g_in, add_sub, done, busy
  );
endinterface

// File: rtl/proc_control_dec3to8.sv
// 3-bit register index to one-hot write enable, gated by en_i.
module dec3to8 (
  input  logic [2:0] idx_i,
  input  logic       en_i,
  output logic [7:0] onehot_o
);
  assign onehot_o = en_i ? (8'b0000_0001 << idx_i) : 8'b0000_0000;
endmodule

// File: rtl/proc_control.sv
// Instruction sequencer: IDLE accepts run and latches ir, T1..T3 drive the datapath enables.
// mv/mvt/undefined finish in T1, add/sub in T3; run is ignored while busy.
module proc_control
  import proc_pkg::*;
(
  input  logic           clk,
  input  logic           resetn,
  proc_control_if.master bus
);

  logic [1:0]  state_q, state_d;
  logic [15:0] ir_q, ir_d;
  logic [2:0]  op, rx, ry;
  logic        imm;
  logic        wr_en;
  logic [3:0]  sel;
  logic        a_en, g_en, sub_en, done_en;

  assign op  = ir_q[15:13];
  assign imm = ir_q[12];
  assign rx  = ir_q[11:9];
  assign ry  = ir_q[2:0];

  always_comb begin
    state_d = state_q;
    ir_d    = ir_q;
    wr_en   = 1'b0;
    sel     = SEL_R0;
    a_en    = 1'b0;
    g_en    = 1'b0;
    sub_en  = 1'b0;
    done_en = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.run) begin
          ir_d    = bus.instr;
          state_d = ST_T1;
        end
      end
      ST_T1: begin
        case (op)
          OP_MV: begin
            sel     = imm ? SEL_D : sel_reg(ry);
            wr_en   = 1'b1;
            done_en = 1'b1;
            state_d = ST_IDLE;
          end
          OP_MVT: begin
            sel     = SEL_DT;
            wr_en   = 1'b1;
            done_en = 1'b1;
            state_d = ST_IDLE;
          end
          OP_ADD, OP_SUB: begin
            sel     = sel_reg(rx);
            a_en    = 1'b1;
            state_d = ST_T2;
          end
          default: begin
            // Undefined opcodes retire immediately without touching the datapath.
            done_en = 1'b1;
            state_d = ST_IDLE;
          end
        endcase
      end
      ST_T2: begin
        sel     = imm ? SEL_D : sel_reg(ry);
        g_en    = 1'b1;
        sub_en  = (op == OP_SUB);
        state_d = ST_T3;
      end
      default: begin
        sel     = SEL_G;
        wr_en   = 1'b1;
        done_en = 1'b1;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= ST_IDLE;
      ir_q    <= 16'h0000;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
    end
  end

  dec3to8 u_dec (
    .idx_i    (rx),
    .en_i     (wr_en),
    .onehot_o (bus.r_in)
  );

  assign bus.ir      = ir_q;
  assign bus.bus_sel = sel;
  assign bus.a_in    = a_en;
  assign bus.g_in    = g_en;
  assign bus.add_sub = sub_en;
  assign bus.done    = done_en;
  assign bus.busy    = (state_q != ST_IDLE);

endmodule

// File: tb/tb_proc_control.sv
// Directed vector bench for proc_control: per-cycle table plus latency and mid-instruction reset sequences.
module tb_proc_control;

  logic clk = 1'b0;
  logic resetn = 1'b0;

  proc_control_if bus ();

  proc_control dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus.master)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        busy;
    logic        done;
    logic [3:0]  sel;
    logic [7:0]  rin;
    logic        a;
    logic        g;
    logic        as;
    logic [15:0] ir;
  } obs_t;

  typedef struct {
    logic        rst_n;
    logic        run;
    logic [15:0] instr;
    obs_t        exp;
  } vec_t;

  localparam int NVEC = 24;
  vec_t vecs [NVEC];
  int   checks = 0;
  int   failures = 0;
  int   lat;

  function automatic vec_t mk(input logic rst_n, input logic run, input logic [15:0] instr,
                              input logic busy, input logic done, input logic [3:0] sel,
                              input logic [7:0] rin, input logic a, input logic g,
                              input logic as, input logic [15:0] ir);
    vec_t v;
    v.rst_n = rst_n;
    v.run   = run;
    v.instr = instr;
    v.exp   = '{busy: busy, done: done, sel: sel, rin: rin, a: a, g: g, as: as, ir: ir};
    return v;
  endfunction

  function automatic obs_t observe();
    obs_t o;
    o.busy = bus.busy;
    o.done = bus.done;
    o.sel  = bus.bus_sel;
    o.rin  = bus.r_in;
    o.a    = bus.a_in;
    o.g    = bus.g_in;
    o.as   = bus.add_sub;
    o.ir   = bus.ir;
    return o;
  endfunction

  task automatic check_obs(input int tag, input obs_t exp);
    obs_t got;
    got = observe();
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL outputs step%0d got busy=%b done=%b sel=%0d r_in=%h a=%b g=%b as=%b ir=%h required busy=%b done=%b sel=%0d r_in=%h a=%b g=%b as=%b ir=%h",
               tag, got.busy, got.done, got.sel, got.rin, got.a, got.g, got.as, got.ir,
               exp.busy, exp.done, exp.sel, exp.rin, exp.a, exp.g, exp.as, exp.ir);
    end
  endtask

  // At most one write enable, and never a_in/g_in/r_in together.
  task automatic check_excl(input int tag);
    int n;
    n = $countones(bus.r_in) + int'(bus.a_in) + int'(bus.g_in);
    checks++;
    if (n > 1) begin
      failures++;
      $display("FAIL exclusive_enables step%0d got %0d active enables required at most 1", tag, n);
    end
  endtask

  initial begin
    vecs[0]  = mk(1, 1, 16'h2605, 0, 0, 4'd0,  8'h00, 0, 0, 0, 16'h0000);
    vecs[1]  = mk(1, 0, 16'h0000, 1, 1, 4'd10, 8'h08, 0, 0, 0, 16'h2605);
    vecs[2]  = mk(1, 1, 16'h1E1A, 0, 0, 4'd0,  8'h00, 0, 0, 0, 16'h2605);
    vecs[3]  = mk(1, 0, 16'h0000, 1, 1, 4'd9,  8'h80, 0, 0, 0, 16'h1E1A);
    vecs[4]  = mk(1, 1, 16'h4205, 0, 0, 4'd0,  8'h00, 0, 0, 0, 16'h1E1A);
    vecs[5]  = mk(1, 1, 16'h7403, 1, 0, 4'd1,  8'h00, 1, 0, 0, 16'h4205);
    vecs[6]  = mk(1, 1, 16'h7403, 1, 0, 4'd5,  8'h00, 0, 1, 0, 16'h4205);
    vecs[7]  = mk(1, 1, 16'h7403, 1, 1, 4'd8,  8'h02, 0, 0, 0, 16'h4205);
    vecs[8]  = mk(1, 1, 16'h7403, 0, 0, 4'd0,  8'h00, 0, 0, 0, 16'h4205);
    vecs[9]  = mk(1, 0, 16'h0000, 1, 0, 4'd2,  8'h00, 1, 0, 0, 16'h7403);
    vecs[10] = mk(1, 0, 16'h0000, 1, 0, 4'd9,  8'h00, 0, 1, 1, 16'h7403);
    vecs[11] = mk(1, 0, 16'h0000, 1, 1, 4'd8,  8'h04, 0, 0, 0, 16'h7403);
    vecs[12] = mk(1, 1, 16'h4205, 0, 0, 4'd0,  8'h00, 0, 0, 0, 16'h7403);
    vecs[13] = mk(1, 0, 16'h0000, 1, 0, 4'd1,  8'h00, 1, 0, 0, 16'h4205);
    vecs[14] = mk(0, 1, 16'h4205, 1, 0, 4'd5,  8'h00, 0, 1, 0, 16'h4205);
    vecs[15] = mk(1, 1, 16'hE000, 0, 0, 4'd0,  8'h00, 0, 0, 0, 16'h0000);
    vecs[16] = mk(1, 0, 16'h0000, 1, 1, 4'd0,  8'h00, 0, 0, 0, 16'hE000);
    vecs[17] = mk(1, 1, 16'h4603, 0, 0, 4'd0,  8'h00, 0, 0, 0, 16'hE000);
    vecs[18] = mk(1, 0, 16'h0000, 1, 0, 4'd3,  8'h00, 1, 0, 0, 16'h4603);
    vecs[19] = mk(1, 0, 16'h0000, 1, 0, 4'd3,  8'h00, 0, 1, 0, 16'h4603);
    vecs[20] = mk(1, 0, 16'h0000, 1, 1, 4'd8,  8'h08, 0, 0, 0, 16'h4603);
    vecs[21] = mk(1, 1, 16'h0A06, 0, 0, 4'd0,  8'h00, 0, 0, 0, 16'h4603);
    vecs[22] = mk(1, 0, 16'h0000, 1, 1, 4'd6,  8'h20, 0, 0, 0, 16'h0A06);
    vecs[23] = mk(1, 0, 16'h0000, 0, 0, 4'd0,  8'h00, 0, 0, 0, 16'h0A06);

    // run asserted during reset must not be accepted.
    resetn    = 1'b0;
    bus.run   = 1'b1;
    bus.instr = 16'h2605;
    repeat (2) @(posedge clk);

    // Each row: check outputs of the current cycle, then drive inputs for the next edge.
    for (int i = 0; i < NVEC; i++) begin
      @(negedge clk);
      check_obs(i, vecs[i].exp);
      check_excl(i);
      resetn    = vecs[i].rst_n;
      bus.run   = vecs[i].run;
      bus.instr = vecs[i].instr;
    end

    // sub latency: done must appear in the third cycle after acceptance.
    @(negedge clk);
    bus.run   = 1'b1;
    bus.instr = 16'h7403;
    lat = 0;
    for (int n = 1; n <= 10; n++) begin
      @(negedge clk);
      bus.run = 1'b0;
      if (bus.done === 1'b1) begin
        lat = n;
        break;
      end
    end
    checks++;
    if (lat != 3) begin
      failures++;
      $display("FAIL sub_latency got %0d cycles required 3 (0 = no done within bound)", lat);
    end

    // Reset in T3 with run held high: reset wins, then run held during reset is dropped.
    @(negedge clk);
    bus.run   = 1'b1;
    bus.instr = 16'h4205;
    @(negedge clk);
    bus.run = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check_obs(100, '{busy: 1, done: 1, sel: 4'd8, rin: 8'h02, a: 0, g: 0, as: 0, ir: 16'h4205});
    resetn  = 1'b0;
    bus.run = 1'b1;
    @(negedge clk);
    check_obs(101, '{busy: 0, done: 0, sel: 4'd0, rin: 8'h00, a: 0, g: 0, as: 0, ir: 16'h0000});
    resetn  = 1'b1;
    bus.run = 1'b0;
    @(negedge clk);
    check_obs(102, '{busy: 0, done: 0, sel: 4'd0, rin: 8'h00, a: 0, g: 0, as: 0, ir: 16'h0000});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
